// File: rtl/pcm_pkg.sv
// Shared constants and sample type for the PCM-to-I2S transmit path.
package pcm_pkg;

    localparam int unsigned PCM_W_DEF = 24;
    localparam int unsigned I2S_SLOTS = 32;
    localparam int unsigned I2S_FRAME = 64;

    typedef logic signed [PCM_W_DEF-1:0] pcm_t;

endpackage

// File: rtl/pcm_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop.
module pcm_sync_fifo
    import pcm_pkg::*;
#(
    parameter int unsigned Width = PCM_W_DEF,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           wdata_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     level_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_en, rd_en;

    assign full_o  = (level_q == (AW + 1)'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_en    = push_i && (!full_o || pop_i);
        rd_en    = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        level_d  = level_q + (AW + 1)'(wr_en) - (AW + 1)'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/pcm_i2s_tx.sv
// FIFO-buffered PCM to stereo-duplicated I2S serializer, 64 BCLK per frame, MSB one BCLK after LRCLK.
// Define PCM_I2S_TX_HOLD_EN to repeat the last popped sample on underrun instead of sending silence.
module pcm_i2s_tx
    import pcm_pkg::*;
#(
    parameter int unsigned PCM_W      = PCM_W_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [PCM_W-1:0]         pcm_in,
    input  logic                            pcm_valid,
    input  logic                            tx_en,
    input  logic                            flag_clr,
    output logic                            i2s_bclk,
    output logic                            i2s_lrclk,
    output logic                            i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            underrun
);

    localparam int unsigned DivW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned CntW  = $clog2(I2S_FRAME);
    localparam int unsigned SlotW = $clog2(I2S_SLOTS);
    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);

    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic [PCM_W-1:0] cur_smp_q, cur_smp_d;
    logic [PCM_W-1:0] sh_q, sh_d;
    logic             ovf_q, ovf_d;
    logic             udr_q, udr_d;

    logic             fall_evt, ovf_evt, udr_evt;
    logic [SlotW-1:0] slot;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [PCM_W-1:0] fifo_rdata;
    logic [PCM_W-1:0] fallback;

    pcm_sync_fifo #(
        .Width (PCM_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pcm_valid),
        .pop_i   (fifo_pop),
        .wdata_i (pcm_in),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

`ifdef PCM_I2S_TX_HOLD_EN
    logic [PCM_W-1:0] last_smp_q, last_smp_d;

    assign last_smp_d = fifo_pop ? fifo_rdata : last_smp_q;
    assign fallback   = last_smp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_smp_q <= '0;
        end else begin
            last_smp_q <= last_smp_d;
        end
    end
`else
    assign fallback = '0;
`endif

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        bclk_d    = bclk_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        cur_smp_d = cur_smp_q;
        sh_d      = sh_q;
        fall_evt  = 1'b0;
        fifo_pop  = 1'b0;
        udr_evt   = 1'b0;
        slot      = '0;

        if (tx_en) begin
            if (div_cnt_q == DivLast) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
                fall_evt  = bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end

            if (fall_evt) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                lrclk_d   = bit_cnt_d[CntW-1];
                slot      = bit_cnt_d[SlotW-1:0];
                sdata_d   = 1'b0;
                if (bit_cnt_q == '1) begin
                    // Frame boundary: fetch the next sample for both channels.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        cur_smp_d = fifo_rdata;
                    end else begin
                        udr_evt   = 1'b1;
                        cur_smp_d = fallback;
                    end
                    sh_d = cur_smp_d;
                end else if (slot == '0) begin
                    sh_d = cur_smp_q;
                end else if ({{(32 - SlotW){1'b0}}, slot} <= PCM_W) begin
                    sdata_d = sh_q[PCM_W-1];
                    sh_d    = sh_q << 1;
                end
            end
        end else begin
            div_cnt_d = '0;
            bit_cnt_d = '1;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
        end
    end

    // Sticky flags: a set event in the same cycle beats a clear.
    always_comb begin
        ovf_evt = pcm_valid && fifo_full && !fifo_pop;
        ovf_d   = flag_clr ? 1'b0 : ovf_q;
        udr_d   = flag_clr ? 1'b0 : udr_q;
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end
        if (udr_evt) begin
            udr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '1;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            cur_smp_q <= '0;
            sh_q      <= '0;
            ovf_q     <= 1'b0;
            udr_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            cur_smp_q <= cur_smp_d;
            sh_q      <= sh_d;
            ovf_q     <= ovf_d;
            udr_q     <= udr_d;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign overflow  = ovf_q;
    assign underrun  = udr_q;

endmodule

// File: doc/pcm_i2s_tx.md
# pcm_i2s_tx

Downstream stage of `dsm_decimation_chain`; consumes its 24-bit signed `pcm_out`/`pcm_valid` strobe stream. Buffers samples in a small synchronous FIFO and serialises each one as a stereo-duplicated I2S frame (64 BCLK per frame, 32 per channel) on the system clock. Also reports FIFO level and sticky overflow/underrun flags for the host or testbench.

## Interface

- `PCM_W`, 24: input sample width; must be ≤ 31.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `BCLK_DIV`, 4: `clk` cycles per BCLK half-period; ≥ 2.

- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `pcm_in`  in  PCM_W  signed sample, from `pcm_out`.
- `pcm_valid`  in  1  one-cycle push strobe.
- `tx_en`  in  1  serializer enable; FIFO accepts data regardless.
- `flag_clr`  in  1  one-cycle clear of sticky flags.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select; 0 = left, 1 = right.
- `i2s_sdata`  out  1  serial data, MSB first.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a push was dropped.
- `underrun`  out  1  sticky: a frame started with the FIFO empty.

## Operation

- Reset: FIFO empty; `i2s_bclk`, `i2s_lrclk`, `i2s_sdata`, `overflow`, `underrun` = 0; `fifo_level` = 0; `div_cnt` = 0; `bit_cnt` = 63; `last_smp` = 0.
- Push: `pcm_valid`=1 while not full → write. Full with no pop in the same cycle → sample dropped, `overflow` set. Full with a pop in the same cycle → push accepted, level unchanged.
- Divider: `div_cnt` counts 0..BCLK_DIV-1 while `tx_en`=1. At terminal count it wraps and toggles `i2s_bclk`.
- Falling-edge event (BCLK 1→0): `bit_cnt` increments mod 64. `i2s_lrclk` = (`bit_cnt` ≥ 32) using the new count. `i2s_sdata` updates per the slot rule below.
- Frame load: when `bit_cnt` wraps 63→0, pop the FIFO into `cur_smp` if non-empty. If empty, set `underrun` and load the fallback value (see Configuration).
- Slot rule (p = `bit_cnt` mod 32):
  - p=0 → 0.
  - p=1..PCM_W → `cur_smp[PCM_W-p]`, MSB first, one BCLK after the LRCLK edge (standard I2S).
  - p > PCM_W → 0.
  - Left and right carry the same sample.
- `tx_en`=0: synchronously forces `div_cnt`=0, `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_sdata`=0, `bit_cnt`=63. Dropping it mid-frame abandons the frame; the popped sample is lost.
- `flag_clr` clears both flags. A set event in the same cycle wins.
- `rst` mid-frame: all state returns to reset values on the next edge; FIFO contents are discarded.

## Timing

- BCLK period = 2·BCLK_DIV `clk`; frame = 128·BCLK_DIV `clk` (512 at default).
- After `tx_en` rises: first BCLK rise at cycle BCLK_DIV; first falling edge / frame load at cycle 2·BCLK_DIV.
- `i2s_sdata` and `i2s_lrclk` change only in the same cycle as a BCLK falling edge; all outputs are registered.
- `fifo_level` reflects a push or pop one cycle after it.
- Push-to-pin latency into an idle, empty FIFO: the next frame load, plus 1 BCLK for the MSB.
- Sustainable input rate ≤ clk/(128·BCLK_DIV); a faster rate must eventually overflow.

## Configuration

- `PCM_I2S_TX_HOLD_EN` defined: on underrun, reload `last_smp` (last popped sample).
- Not defined: on underrun, load 0.
- `underrun` flag behaviour is identical in both builds.

## Structure

- Package `pcm_pkg`: `PCM_W` default, `I2S_SLOTS`=32, `I2S_FRAME`=64, typedef `pcm_t` (signed [PCM_W-1:0]).
- Sub-module `pcm_sync_fifo`: depth/width parameterised, with full, empty and level; same `clk`/`rst`.
- The divider, slot counter and shifter stay in the top module.

## Test plan

- Reset, `tx_en`=1, no pushes → `i2s_bclk` period 8 clk; `underrun`=1 at cycle 8; `i2s_sdata` constantly 0.
- Push 0x800001, then `tx_en`=1 → left and right slots each serialise 1,0…0,1 on p=1..24; `fifo_level` 1→0 at the first load.
- 9 pushes back-to-back with `tx_en`=0 → `fifo_level`=8, `overflow`=1; the first 8 samples are emitted in order.
- Push 0x123456, run 2 frames with no further push → frame 2 = 0x123456 with `PCM_I2S_TX_HOLD_EN`, 0 without; `underrun`=1 in both builds.
- Assert `flag_clr` in the same cycle as an overflow event → `overflow` stays 1. Assert it alone → 0.
- Assert `rst` at `bit_cnt`=40 → next cycle all outputs 0, `fifo_level`=0, `bit_cnt`=63.
